// File: rtl/view_sequencer.sv
// view_sequencer: per-frame view-origin sequencer between the register file
// and the coordinate generator. Holds shadow X0/Y0/STEP registers, applies
// them on commit, and hands each frame's parameters over with a
// valid/ready handshake.
// Optional build macro VIEW_SEQ_ANIM_EN adds DX/DY per-frame origin stepping.
module view_sequencer #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr,
  input  logic [2:0]                cfg_addr,
  input  logic [31:0]               cfg_wdata,
  input  logic                      frame_done,
  input  logic                      params_ready,
  output logic                      params_valid,
  output logic signed [COORD_W-1:0] x0,
  output logic signed [COORD_W-1:0] y0,
  output logic [COORD_W-1:0]        step,
  output logic                      busy,
  output logic [FCNT_W-1:0]         frame_count,
  output logic                      frame_irq
);

  localparam logic [2:0] ADDR_X0   = 3'd0;
  localparam logic [2:0] ADDR_Y0   = 3'd1;
  localparam logic [2:0] ADDR_STEP = 3'd2;
  localparam logic [2:0] ADDR_CTRL = 3'd4;
`ifdef VIEW_SEQ_ANIM_EN
  localparam logic [2:0] ADDR_DXY  = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, ARM, RUN, UPDATE} state_t;

  state_t                      state, state_n;
  logic signed [COORD_W-1:0]   sh_x0, sh_x0_n, sh_y0, sh_y0_n;
  logic [COORD_W-1:0]          sh_step, sh_step_n, step_wr;
  logic                        enable, enable_n, commit_pending, commit_set;
  logic                        do_update, frame_inc;
`ifdef VIEW_SEQ_ANIM_EN
  logic signed [7:0]           dx, dx_n, dy, dy_n;
`endif
  logic                        unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:16];

  // Next shadow values; the UPDATE copy reads these so a same-cycle write is seen
  always_comb begin
    sh_x0_n    = sh_x0;
    sh_y0_n    = sh_y0;
    sh_step_n  = sh_step;
    enable_n   = enable;
    commit_set = 1'b0;
    step_wr    = COORD_W'(cfg_wdata[15:0]);
`ifdef VIEW_SEQ_ANIM_EN
    dx_n       = dx;
    dy_n       = dy;
`endif
    if (cfg_wr) begin
      case (cfg_addr)
        ADDR_X0:   sh_x0_n   = COORD_W'($signed(cfg_wdata[15:0]));
        ADDR_Y0:   sh_y0_n   = COORD_W'($signed(cfg_wdata[15:0]));
        ADDR_STEP: sh_step_n = (step_wr == '0) ? COORD_W'(1) : step_wr;
`ifdef VIEW_SEQ_ANIM_EN
        ADDR_DXY: begin
          dx_n = $signed(cfg_wdata[7:0]);
          dy_n = $signed(cfg_wdata[15:8]);
        end
`endif
        ADDR_CTRL: begin
          enable_n   = cfg_wdata[0];
          commit_set = cfg_wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and per-cycle action strobes
  always_comb begin
    state_n   = state;
    do_update = 1'b0;
    frame_inc = 1'b0;
    case (state)
      IDLE: if (enable) state_n = UPDATE;
      UPDATE: begin
        do_update = 1'b1;
        state_n   = ARM;
      end
      ARM: begin
        if (!enable)                            state_n = IDLE;
        else if (params_valid && params_ready)  state_n = RUN;
      end
      RUN: begin
        if (frame_done) begin
          frame_inc = 1'b1;
          state_n   = enable ? UPDATE : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Shadow, active parameter, status and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x0          <= '0;
      sh_y0          <= '0;
      sh_step        <= COORD_W'(1);
      enable         <= 1'b0;
      commit_pending <= 1'b0;
      x0             <= '0;
      y0             <= '0;
      step           <= COORD_W'(1);
      params_valid   <= 1'b0;
      busy           <= 1'b0;
      frame_irq      <= 1'b0;
      frame_count    <= '0;
`ifdef VIEW_SEQ_ANIM_EN
      dx             <= '0;
      dy             <= '0;
`endif
    end else begin
      sh_x0        <= sh_x0_n;
      sh_y0        <= sh_y0_n;
      sh_step      <= sh_step_n;
      enable       <= enable_n;
`ifdef VIEW_SEQ_ANIM_EN
      dx           <= dx_n;
      dy           <= dy_n;
`endif
      params_valid <= (state_n == ARM);
      busy         <= (state_n != IDLE);
      frame_irq    <= frame_inc;
      if (frame_inc) frame_count <= frame_count + FCNT_W'(1);

      // A commit arriving during UPDATE is kept for the following UPDATE
      if (commit_set)                       commit_pending <= 1'b1;
      else if (do_update && commit_pending) commit_pending <= 1'b0;

      if (do_update && commit_pending) begin
        x0   <= sh_x0_n;
        y0   <= sh_y0_n;
        step <= sh_step_n;
      end
`ifdef VIEW_SEQ_ANIM_EN
      else if (do_update) begin
        x0 <= x0 + COORD_W'(dx);
        y0 <= y0 + COORD_W'(dy);
      end
`endif
    end
  end

endmodule

// File: tb/tb_view_sequencer.sv
// tb_view_sequencer: table vectors plus hand-written sequences for
// view_sequencer; per-frame parameters are checked through a scoreboard.
module tb_view_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned FW = 16;
`ifdef VIEW_SEQ_ANIM_EN
  localparam logic [15:0] DX = 16'd2;
  localparam logic [15:0] DY = 16'd1;  // subtracted: DY register holds -1
`else
  localparam logic [15:0] DX = 16'd0;
  localparam logic [15:0] DY = 16'd0;
`endif

  logic                 clk, reset, cfg_wr, frame_done, params_ready;
  logic [2:0]           cfg_addr;
  logic [31:0]          cfg_wdata;
  logic                 params_valid, busy, frame_irq;
  logic signed [CW-1:0] x0, y0;
  logic [CW-1:0]        step;
  logic [FW-1:0]        frame_count;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
  } exp_t;

  typedef struct packed {
    logic [31:0] wx;
    logic [31:0] wy;
    logic [31:0] ws;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] es;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[4];
  int          tests = 0;
  int          fails = 0;
  int          irq_seen = 0;
  int          frames_done = 0;
  logic [15:0] fc_exp, cur_x, cur_y, cur_s;

  view_sequencer #(.COORD_W(CW), .FCNT_W(FW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .frame_done   (frame_done),
    .params_ready (params_ready),
    .params_valid (params_valid),
    .x0           (x0),
    .y0           (y0),
    .step         (step),
    .busy         (busy),
    .frame_count  (frame_count),
    .frame_irq    (frame_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with frame_irq high
  always @(negedge clk) if (!reset && frame_irq) irq_seen <= irq_seen + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!params_valid && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!params_valid) begin
      fails++;
      $display("FAIL %s: params_valid timeout, got 0 expected 1", name);
    end
  endtask

  // Wait for offered parameters, compare against scoreboard, then accept them
  task automatic handshake(input string name);
    exp_t e;
    wait_valid(name);
    if (params_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL %s: unexpected params_valid, got 1 expected no pending frame", name);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_x0", name), x0, e.x);
        check($sformatf("%s_y0", name), y0, e.y);
        check($sformatf("%s_step", name), step, e.s);
      end
    end
    params_ready = 1'b1;
    tick();
    params_ready = 1'b0;
    check($sformatf("%s_pv_drop", name), 16'(params_valid), 16'd0);
    check($sformatf("%s_busy_run", name), 16'(busy), 16'd1);
  endtask

  // End the current frame from RUN; optionally write a register during UPDATE
  task automatic next_frame(input string name, input logic [15:0] ex, input logic [15:0] ey,
                            input logic [15:0] es, input logic upd_wr,
                            input logic [2:0] ua, input logic [31:0] ud);
    sb.push_back({ex, ey, es});
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    frames_done++;
    fc_exp++;
    check($sformatf("%s_irq", name), 16'(frame_irq), 16'd1);
    check($sformatf("%s_count", name), frame_count, fc_exp);
    if (upd_wr) cfg(ua, ud);
    handshake(name);
  endtask

  initial begin
    vecs[0] = '{wx: 32'h0000_1234, wy: 32'h0000_8000, ws: 32'h0000_0000,
                ex: 16'h1234, ey: 16'h8000, es: 16'h0001};
    vecs[1] = '{wx: 32'hABCD_7FFF, wy: 32'h0000_FFFF, ws: 32'h0001_0000,
                ex: 16'h7FFF, ey: 16'hFFFF, es: 16'h0001};
    vecs[2] = '{wx: 32'h0000_0000, wy: 32'h0000_0000, ws: 32'h0000_FFFF,
                ex: 16'h0000, ey: 16'h0000, es: 16'hFFFF};
    vecs[3] = '{wx: 32'h0000_FFFF, wy: 32'h0000_0000, ws: 32'h0000_0001,
                ex: 16'hFFFF, ey: 16'h0000, es: 16'h0001};

    reset = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    frame_done = 1'b0; params_ready = 1'b0; fc_exp = '0;

    // Reset values before any clock edge
    #2;
    check("rst_pv", 16'(params_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_irq", 16'(frame_irq), 16'd0);
    check("rst_count", frame_count, 16'd0);
    check("rst_x0", x0, 16'd0);
    check("rst_y0", y0, 16'd0);
    check("rst_step", step, 16'd1);
    tick();
    reset = 1'b0;
    tick();

    // First commit: params_valid two cycles after the CTRL write
    cfg(3'd0, 32'h0000_FF00);
    cfg(3'd1, 32'h0000_0100);
    cfg(3'd2, 32'h0000_0004);
    sb.push_back({16'hFF00, 16'h0100, 16'h0004});
    cfg(3'd4, 32'h0000_0003);
    check("b_pv_c0", 16'(params_valid), 16'd0);
    check("b_busy_c0", 16'(busy), 16'd0);
    tick();
    check("b_pv_c1", 16'(params_valid), 16'd0);
    check("b_busy_c1", 16'(busy), 16'd1);
    tick();
    check("b_pv_c2", 16'(params_valid), 16'd1);

    // params_ready low for 10 cycles: parameters hold, no handover
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b_hold_pv", 16'(params_valid), 16'd1);
      check("b_hold_x0", x0, 16'hFF00);
      check("b_hold_y0", y0, 16'h0100);
      check("b_hold_step", step, 16'h0004);
    end
    handshake("b_hs");
    cur_x = 16'hFF00; cur_y = 16'h0100; cur_s = 16'h0004;

    // Per-frame stepping DX=+2 DY=-1 (no movement without the animation build)
    cfg(3'd3, 32'h0000_FF02);
    for (int i = 0; i < 3; i++) begin
      cur_x = cur_x + DX; cur_y = cur_y - DY;
      next_frame("c_anim", cur_x, cur_y, cur_s, 1'b0, 3'd0, 32'd0);
    end
    check("c_count3", frame_count, 16'd3);
    check("c_irq3", 16'(irq_seen), 16'd3);

    // Commit written during UPDATE takes effect one frame later
    cfg(3'd0, 32'h0000_1234);
    cur_x = cur_x + DX; cur_y = cur_y - DY;
    next_frame("d_late_commit", cur_x, cur_y, cur_s, 1'b1, 3'd4, 32'h0000_0003);
    cur_x = 16'h1234; cur_y = 16'h0100;
    next_frame("d_commit_applied", cur_x, cur_y, cur_s, 1'b0, 3'd0, 32'd0);

    // Shadow write in the committing UPDATE cycle is visible to the commit
    cfg(3'd4, 32'h0000_0003);
    cur_x = 16'h0777;
    next_frame("e_bypass", cur_x, cur_y, cur_s, 1'b1, 3'd0, 32'h0000_0777);

    // Table: commits with truncation, STEP=0 mapping, ignored addresses 5-7
    for (int i = 0; i < 4; i++) begin
      cfg(3'd0, vecs[i].wx);
      cfg(3'd1, vecs[i].wy);
      cfg(3'd2, vecs[i].ws);
      cfg(3'd5, 32'hFFFF_FFFF);
      cfg(3'd6, 32'h0000_0000);
      cfg(3'd7, 32'hFFFF_FFFC);
      cfg(3'd4, 32'h0000_0003);
      next_frame($sformatf("f_vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es,
                 1'b0, 3'd0, 32'd0);
    end
    cur_x = 16'hFFFF; cur_y = 16'h0000; cur_s = 16'h0001;

    // Stepping wraps modulo 2^16
    cur_x = cur_x + DX; cur_y = cur_y - DY;
    next_frame("g_wrap", cur_x, cur_y, cur_s, 1'b0, 3'd0, 32'd0);

    // Enable cleared during RUN: running frame completes, then IDLE
    cfg(3'd4, 32'h0000_0000);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    fc_exp++;
    frames_done++;
    check("h_irq", 16'(frame_irq), 16'd1);
    check("h_count", frame_count, fc_exp);
    check("h_busy", 16'(busy), 16'd0);
    check("h_pv", 16'(params_valid), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("h_idle_pv", 16'(params_valid), 16'd0);
      check("h_idle_busy", 16'(busy), 16'd0);
    end

    // frame_done outside RUN is ignored
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    check("h_ignored_count", frame_count, fc_exp);
    check("h_ignored_irq", 16'(irq_seen), 16'(frames_done));

    // ARM with enable cleared drops to IDLE without a handshake
    cfg(3'd4, 32'h0000_0001);
    wait_valid("i_arm");
    cur_x = cur_x + DX; cur_y = cur_y - DY;
    check("i_x0", x0, cur_x);
    check("i_y0", y0, cur_y);
    cfg(3'd4, 32'h0000_0000);
    check("i_pv_still", 16'(params_valid), 16'd1);
    tick();
    check("i_pv_idle", 16'(params_valid), 16'd0);
    check("i_busy_idle", 16'(busy), 16'd0);

    // Reset asserted in ARM acts without a clock edge
    cfg(3'd4, 32'h0000_0003);
    wait_valid("j_arm");
    check("j_x0", x0, 16'hFFFF);
    check("j_step", step, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check("j_rst_pv", 16'(params_valid), 16'd0);
    check("j_rst_busy", 16'(busy), 16'd0);
    check("j_rst_irq", 16'(frame_irq), 16'd0);
    check("j_rst_count", frame_count, 16'd0);
    check("j_rst_x0", x0, 16'd0);
    check("j_rst_y0", y0, 16'd0);
    check("j_rst_step", step, 16'd1);
    tick();
    reset = 1'b0;
    fc_exp = '0;
    tick();
    tick();
    check("j_post_busy", 16'(busy), 16'd0);
    check("j_post_pv", 16'(params_valid), 16'd0);
    check("j_sb_empty", 16'(sb.size()), 16'd0);

    // Commit after reset sees reset shadows; DX/DY were cleared too
    sb.push_back({16'h0000, 16'h0000, 16'h0001});
    cfg(3'd4, 32'h0000_0003);
    handshake("k_shadow_reset");
    next_frame("k_delta_reset", 16'h0000, 16'h0000, 16'h0001, 1'b0, 3'd0, 32'd0);

    tick();
    check("end_sb_empty", 16'(sb.size()), 16'd0);
    check("end_irq_total", 16'(irq_seen), 16'(frames_done));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/view_sequencer.md
VIEW_SEQUENCER -- requirements
Module: view_sequencer

Interface
REQ-001 SHALL have parameter COORD_W, default 16, width of the signed view-origin and step words.
REQ-002 SHALL have parameter FCNT_W, default 16, width of the frame counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_wr  input  1  single-cycle write strobe from the AXI-Lite register file.
REQ-006 SHALL have port cfg_addr  input  3  shadow register index.
REQ-007 SHALL have port cfg_wdata  input  32  write data.
REQ-008 SHALL have port frame_done  input  1  single-cycle pulse from the coordinate generator when the last pixel of a frame is accepted.
REQ-009 SHALL have port params_ready  input  1  coordinate generator accepts a new frame parameter set.
REQ-010 SHALL have port params_valid  output  1  x0/y0/step are valid for the next frame.
REQ-011 SHALL have ports x0, y0  output  COORD_W each  signed top-left coordinate of the next frame.
REQ-012 SHALL have port step  output  COORD_W  unsigned per-pixel coordinate increment, never zero.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port frame_count  output  FCNT_W  number of completed frames.
REQ-015 SHALL have port frame_irq  output  1  single-cycle pulse per completed frame.

Function
REQ-016 SHALL hold shadow registers written by cfg_wr: addr 0 X0 = wdata[15:0], 1 Y0, 2 STEP, 3 DX = wdata[7:0] and DY = wdata[15:8] (signed), 4 CTRL = bit0 enable and bit1 commit; addresses 5-7 SHALL be ignored.
REQ-017 SHALL store a STEP write of 0 as 1.
REQ-018 SHALL not self-store commit; a CTRL write with bit1=1 SHALL set the internal commit_pending flag.
REQ-019 SHALL implement states IDLE, ARM, RUN, UPDATE.
REQ-020 SHALL, in IDLE, move to UPDATE when enable=1; UPDATE SHALL always move to ARM one cycle later.
REQ-021 SHALL, in UPDATE, copy the shadow X0/Y0/STEP into the active registers and clear commit_pending if commit_pending=1; otherwise add DX to x0 and DY to y0 (sign-extended, modulo 2^COORD_W wrap).
REQ-022 SHALL, in ARM, assert params_valid and hold x0/y0/step stable until params_valid && params_ready; it SHALL then move to RUN.
REQ-023 SHALL, in RUN, keep params_valid low and, on frame_done, increment frame_count (wrapping at 2^FCNT_W), pulse frame_irq for one cycle, and move to UPDATE if enable=1, else to IDLE.
REQ-024 SHALL ignore frame_done in any state except RUN.
REQ-025 SHALL let a frame that has already started finish after enable is cleared; ARM with enable=0 SHALL go to IDLE without a handshake.
REQ-026 SHALL, when a commit write lands in the same cycle as UPDATE, leave the current UPDATE using the pre-write state and apply the commit at the next UPDATE.
REQ-027 SHALL, when a shadow write coincides with a commit write, make that written value visible to the commit.
REQ-028 SHALL drive all outputs from registers; params_valid SHALL be a registered decode of ARM.

Reset
REQ-029 SHALL, while reset=1, immediately force state=IDLE, params_valid=0, busy=0, frame_irq=0, frame_count=0, x0=y0=0, step=1, all shadows 0 except STEP=1, enable=0, commit_pending=0.
REQ-030 SHALL abandon any handshake or frame in progress when reset is asserted mid-operation.

Configuration
REQ-031 SHALL, with VIEW_SEQ_ANIM_EN defined, implement DX/DY registers and the per-frame stepping of REQ-021.
REQ-032 SHALL, without VIEW_SEQ_ANIM_EN, leave DX/DY unimplemented (writes to addr 3 ignored) and leave x0/y0 unchanged in UPDATE except on commit.

Verification
REQ-033 SHALL cover: write X0=0xFF00, Y0=0x0100, STEP=4, CTRL=0x3 -> params_valid in 2 cycles, x0=0xFF00, y0=0x0100, step=4.
REQ-034 SHALL cover: DX=+2, DY=-1 with ANIM_EN, 3 frame_done pulses -> x0 steps 0xFF02/0xFF04/0xFF06, y0 steps 0x00FF/0x00FE/0x00FD, frame_count=3, 3 frame_irq pulses.
REQ-035 SHALL cover: STEP write of 0 then commit -> step=1.
REQ-036 SHALL cover: params_ready held low 10 cycles -> params_valid and x0/y0/step stay stable; no transition to RUN.
REQ-037 SHALL cover: clear enable during RUN then frame_done -> frame_count increments, state IDLE, busy=0, params_valid stays 0.
REQ-038 SHALL cover: reset asserted in ARM -> params_valid=0 with no clock edge and all REQ-029 values present.
